sound_mem_arbiter: RTL and testbench
====================================

Name: sound_mem_arbiter

Overview:
- Shares the single sound-RAM SDRAM read/write port between two requesters: the GLU host-access path (reads and writes) and the DOC oscillator wavetable fetch path (reads only).
- Sits between sound_glu's two memory ports and the SDRAM controller port. It replaces plain combinational OR-muxing with a sequenced, one-transaction-at-a-time arbiter.
- The arbiter gives DOC priority and bounds GLU starvation, with a timeout for an unresponsive memory.

Parameters:
- ADDR_W, 24, memory address width
- DATA_W, 32, memory data width
- DOC_STREAK, 4, maximum consecutive DOC grants while GLU is pending before GLU is forced
- TIMEOUT_CYCLES, 255, WAIT cycles without mem_ready_i before the transaction is abandoned

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- glu_rd_i  in  1  GLU read request, held until glu_ack_o
- glu_wr_i  in  1  GLU write request, held until glu_ack_o
- glu_addr_i  in  ADDR_W  GLU address
- glu_data_i  in  DATA_W  GLU write data
- glu_be_i  in  DATA_W/8  GLU byte enables
- glu_q_o  out  DATA_W  GLU read data, registered
- glu_ack_o  out  1  one-cycle completion pulse
- doc_rd_i  in  1  DOC read request, held until doc_ack_o
- doc_addr_i  in  ADDR_W  DOC address
- doc_q_o  out  DATA_W  DOC read data, registered
- doc_ack_o  out  1  one-cycle completion pulse
- mem_rd_o  out  1  one-cycle read strobe
- mem_wr_o  out  1  one-cycle write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_ready_i  in  1  completion pulse from the controller
- mem_q_i  in  DATA_W  read data, valid with mem_ready_i
- timeout_o  out  1  one-cycle pulse, coincident with the ack of an abandoned transaction
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset is asynchronous. On reset every output is 0, state goes to IDLE, and the streak and timeout counters clear. Any in-flight transaction is dropped with no ack. A late mem_ready_i after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if any request is pending, pick a winner and register the winner id, address, data and byte enables (mem_data_o/mem_be_o are 0 for reads). Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: assert mem_rd_o or mem_wr_o for exactly one cycle. Go to WAIT.
  - WAIT: on mem_ready_i, capture mem_q_i into the winner's q register (writes leave q unchanged) and go to ACK. If the timeout counter reaches TIMEOUT_CYCLES first, load the winner's q with 0, set the pending-timeout flag and go to ACK.
  - ACK: pulse the winner's ack for one cycle, plus timeout_o if the flag is set. Go to IDLE.
- mem_addr_o, mem_data_o and mem_be_o are stable from ISSUE through the last WAIT cycle.
- Latency: a request sampled in IDLE at cycle N gives a strobe at N+1. If mem_ready_i arrives at cycle M, the ack is at M+1. The minimum request-to-ack is 3 cycles, with ready in the cycle immediately after the strobe.
- Requesters drop the request in the cycle after ack. IDLE always follows ACK, so no double grant occurs.
- mem_ready_i outside WAIT is ignored.
- Priority:
  - DOC wins a simultaneous request unless the streak count equals DOC_STREAK and glu is pending; then GLU wins.
  - The streak counter increments on each DOC grant made while GLU is pending. It saturates at DOC_STREAK.
  - It clears on a GLU grant, or on a DOC grant with GLU not pending.
- If glu_rd_i and glu_wr_i are both high, the request is treated as a write.
- q registers hold their value until the next completion for that requester.

Decomposition:
- Shared package sound_mem_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, ACK}
  - the requester enum {REQ_GLU, REQ_DOC}
  - the default ADDR_W/DATA_W constants
- One sub-module is natural: sound_mem_grant. It contains the priority decision and the streak counter, outputs the winner id, and takes a grant-strobe input from the FSM.

Test Plan:
- Lone DOC read: doc_addr 0x001234; memory ready 3 cycles after the strobe with q 0xDEADBEEF -> exactly one mem_rd_o pulse carrying 0x001234; doc_q_o = 0xDEADBEEF; doc_ack_o 4 cycles after the strobe; glu_ack_o never asserts.
- Simultaneous requests: GLU read 0x000010 and DOC read 0x000020 in the same cycle -> DOC serviced first, then GLU; two strobes with addresses 0x20 then 0x10.
- Starvation bound: DOC_STREAK=4, DOC re-requests continuously, GLU held pending -> grant order D,D,D,D,G,D.
- GLU write: addr 0x00ABCD, data 0x11223344, be 0x3 -> one mem_wr_o pulse carrying the same addr, data and be; glu_q_o unchanged; glu_ack_o pulses.
- Timeout: DOC read with no mem_ready_i -> doc_ack_o and timeout_o pulse together TIMEOUT_CYCLES+1 cycles after the strobe; doc_q_o = 0; the next request is serviced normally.
- Reset in WAIT: assert reset_n_i low mid-transaction, then ready arrives after release -> all outputs 0, no ack, late ready ignored; a fresh GLU read then completes normally.

Source files
------------

// File: rtl/sound_mem_pkg.sv
// Shared types for the sound-RAM arbiter: FSM states, requester ids and default widths.
package sound_mem_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  typedef enum logic {
    REQ_GLU,
    REQ_DOC
  } req_e;

endpackage

// File: rtl/sound_mem_grant.sv
// Priority decision between GLU and DOC: DOC normally wins, but a run of DOC
// grants while GLU waits is capped so GLU is eventually forced through.
module sound_mem_grant
  import sound_mem_pkg::*;
#(
  parameter int DOC_STREAK = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic glu_req_i,
  input  logic doc_req_i,
  input  logic grant_i,
  output req_e winner_o
);

  localparam int SW = $clog2(DOC_STREAK + 2);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DOC_STREAK);

  logic [SW-1:0] streak_q, streak_d;

  always_comb begin
    winner_o = REQ_GLU;
    if (doc_req_i && !(glu_req_i && (streak_q == STREAK_MAX))) begin
      winner_o = REQ_DOC;
    end
  end

  // Only DOC wins taken at GLU's expense extend the streak; anything else resets it.
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if ((winner_o == REQ_DOC) && glu_req_i) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/sound_mem_arbiter.sv
// Sequenced one-transaction-at-a-time arbiter sharing the sound-RAM port
// between the GLU host path and the DOC wavetable fetch path.
module sound_mem_arbiter
  import sound_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int DOC_STREAK     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  glu_rd_i,
  input  logic                  glu_wr_i,
  input  logic [ADDR_W-1:0]     glu_addr_i,
  input  logic [DATA_W-1:0]     glu_data_i,
  input  logic [DATA_W/8-1:0]   glu_be_i,
  output logic [DATA_W-1:0]     glu_q_o,
  output logic                  glu_ack_o,
  input  logic                  doc_rd_i,
  input  logic [ADDR_W-1:0]     doc_addr_i,
  output logic [DATA_W-1:0]     doc_q_o,
  output logic                  doc_ack_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_W-1:0]     mem_q_i,
  output logic                  timeout_o,
  output logic                  busy_o
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  req_e               owner_q, owner_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [DATA_W-1:0]  glu_q_q, glu_q_d;
  logic [DATA_W-1:0]  doc_q_q, doc_q_d;
  logic               to_flag_q, to_flag_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;

  logic glu_pend;
  logic grant;
  req_e winner;

  assign glu_pend = glu_rd_i | glu_wr_i;
  assign grant    = (state_q == IDLE) && (glu_pend || doc_rd_i);

  sound_mem_grant #(
    .DOC_STREAK (DOC_STREAK)
  ) u_grant (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .glu_req_i (glu_pend),
    .doc_req_i (doc_rd_i),
    .grant_i   (grant),
    .winner_o  (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    glu_q_d   = glu_q_q;
    doc_q_d   = doc_q_q;
    to_flag_d = to_flag_q;
    tcnt_d    = tcnt_q;

    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d   = winner;
          to_flag_d = 1'b0;
          tcnt_d    = '0;
          state_d   = ISSUE;
          // A GLU request with both strobes high is serviced as a write.
          if (winner == REQ_GLU) begin
            wr_d   = glu_wr_i;
            addr_d = glu_addr_i;
            data_d = glu_wr_i ? glu_data_i : '0;
            be_d   = glu_wr_i ? glu_be_i : '0;
          end else begin
            wr_d   = 1'b0;
            addr_d = doc_addr_i;
            data_d = '0;
            be_d   = '0;
          end
        end
      end

      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (mem_ready_i) begin
          if (!wr_q) begin
            if (owner_q == REQ_GLU) glu_q_d = mem_q_i;
            else                    doc_q_d = mem_q_i;
          end
          state_d = ACK;
        end else if (tcnt_q == TO_LAST) begin
          if (owner_q == REQ_GLU) glu_q_d = '0;
          else                    doc_q_d = '0;
          to_flag_d = 1'b1;
          state_d   = ACK;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      owner_q   <= REQ_GLU;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      glu_q_q   <= '0;
      doc_q_q   <= '0;
      to_flag_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      glu_q_q   <= glu_q_d;
      doc_q_q   <= doc_q_d;
      to_flag_q <= to_flag_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign mem_rd_o   = (state_q == ISSUE) && !wr_q;
  assign mem_wr_o   = (state_q == ISSUE) && wr_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign mem_be_o   = be_q;
  assign glu_q_o    = glu_q_q;
  assign doc_q_o    = doc_q_q;
  assign glu_ack_o  = (state_q == ACK) && (owner_q == REQ_GLU);
  assign doc_ack_o  = (state_q == ACK) && (owner_q == REQ_DOC);
  assign timeout_o  = (state_q == ACK) && to_flag_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sound_mem_arbiter.sv
// Scoreboard bench for sound_mem_arbiter: drivers push expected acks, a
// negedge monitor checks strobes against a priority model and acks against the queues.
module tb_sound_mem_arbiter;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int DOC_STREAK = 4;
  localparam int TO         = 40;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              glu_rd_i = 1'b0, glu_wr_i = 1'b0;
  logic [ADDR_W-1:0] glu_addr_i = '0;
  logic [DATA_W-1:0] glu_data_i = '0;
  logic [BE_W-1:0]   glu_be_i = '0;
  logic [DATA_W-1:0] glu_q_o;
  logic              glu_ack_o;
  logic              doc_rd_i = 1'b0;
  logic [ADDR_W-1:0] doc_addr_i = '0;
  logic [DATA_W-1:0] doc_q_o;
  logic              doc_ack_o;
  logic              mem_rd_o, mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BE_W-1:0]   mem_be_o;
  logic              mem_ready_i = 1'b0;
  logic [DATA_W-1:0] mem_q_i = '0;
  logic              timeout_o, busy_o;

  sound_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DOC_STREAK(DOC_STREAK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .glu_rd_i(glu_rd_i), .glu_wr_i(glu_wr_i), .glu_addr_i(glu_addr_i),
    .glu_data_i(glu_data_i), .glu_be_i(glu_be_i), .glu_q_o(glu_q_o), .glu_ack_o(glu_ack_o),
    .doc_rd_i(doc_rd_i), .doc_addr_i(doc_addr_i), .doc_q_o(doc_q_o), .doc_ack_o(doc_ack_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory contents seen by reads: a fixed function of the address.
  function automatic logic [DATA_W-1:0] rd_value(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction

  typedef struct {
    logic [DATA_W-1:0] q;
    bit                to;
  } ack_exp_t;

  ack_exp_t          exp_glu[$];
  ack_exp_t          exp_doc[$];
  logic [DATA_W-1:0] glu_q_model = '0;

  // Memory responder: rsp_delay 0 = silent, -1 = random 1..4 cycles, else fixed.
  int                rsp_delay = -1;
  bit                rsp_ovr_en = 1'b0;
  logic [DATA_W-1:0] rsp_ovr = '0;
  bit                late_req = 1'b0;
  int                ready_cyc = 0;

  initial begin
    int d;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk_i);
      if (late_req) begin
        late_req = 1'b0;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1; mem_q_i = 32'hBAD0BAD0;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
      end else if (reset_n_i && (mem_rd_o || mem_wr_o) && rsp_delay != 0) begin
        a = mem_addr_o;
        d = (rsp_delay < 0) ? int'($urandom_range(1, 4)) : rsp_delay;
        repeat (d) @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        mem_q_i     = rsp_ovr_en ? rsp_ovr : rd_value(a);
        ready_cyc   = cyc;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        mem_q_i     = $urandom;
      end
    end
  end

  // Monitor state: request snapshot of the previous (decision) cycle and the priority model.
  bit                prev_glu_p = 0, prev_glu_wr = 0, prev_doc_p = 0;
  logic [ADDR_W-1:0] prev_glu_addr = '0, prev_doc_addr = '0;
  logic [DATA_W-1:0] prev_glu_data = '0;
  logic [BE_W-1:0]   prev_glu_be = '0;
  int                run = 0;
  bit                owner_valid = 0, owner_doc = 0;
  int                strobe_cyc = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  bit                grant_log[$];

  task automatic ack_check(input bit is_doc);
    ack_exp_t e;
    int       exp_cyc;
    if (is_doc ? (exp_doc.size() == 0) : (exp_glu.size() == 0)) begin
      checkOutput(is_doc ? "doc_ack_unexpected" : "glu_ack_unexpected", 1, 0);
      return;
    end
    e = is_doc ? exp_doc.pop_front() : exp_glu.pop_front();
    checkOutput(is_doc ? "doc_q" : "glu_q", is_doc ? doc_q_o : glu_q_o, e.q);
    checkOutput("ack_timeout_flag", timeout_o, e.to);
    checkOutput("ack_owner", {owner_valid, owner_doc}, {1'b1, is_doc});
    exp_cyc = e.to ? (strobe_cyc + TO + 1) : (ready_cyc + 1);
    checkOutput("ack_latency", cyc, exp_cyc);
    owner_valid = 0;
  endtask

  initial begin
    bit win_doc;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        owner_valid = 0;
        run = 0;
      end else begin
        if (mem_rd_o || mem_wr_o) begin
          checkOutput("strobe_outstanding", owner_valid, 0);
          if (!prev_glu_p && !prev_doc_p) checkOutput("strobe_no_request", 1, 0);
          win_doc = prev_doc_p && !(prev_glu_p && run == DOC_STREAK);
          if (win_doc && prev_glu_p) run = (run < DOC_STREAK) ? run + 1 : run;
          else run = 0;
          if (win_doc) begin
            exp_addr = prev_doc_addr;
            checkOutput("strobe_rd_wr", {mem_rd_o, mem_wr_o}, 2'b10);
            checkOutput("strobe_addr", mem_addr_o, exp_addr);
            checkOutput("strobe_data_be", {mem_data_o, mem_be_o}, '0);
          end else begin
            exp_addr = prev_glu_addr;
            checkOutput("strobe_rd_wr", {mem_rd_o, mem_wr_o}, prev_glu_wr ? 2'b01 : 2'b10);
            checkOutput("strobe_addr", mem_addr_o, exp_addr);
            checkOutput("strobe_data_be", {mem_data_o, mem_be_o},
                        prev_glu_wr ? {prev_glu_data, prev_glu_be} : '0);
          end
          grant_log.push_back(win_doc);
          owner_valid = 1;
          owner_doc   = win_doc;
          strobe_cyc  = cyc;
        end else if (owner_valid && busy_o && !glu_ack_o && !doc_ack_o) begin
          checkOutput("addr_stable", mem_addr_o, exp_addr);
        end
        if (glu_ack_o && doc_ack_o) checkOutput("dual_ack", 1, 0);
        if (glu_ack_o) ack_check(1'b0);
        if (doc_ack_o) ack_check(1'b1);
        if (timeout_o && !glu_ack_o && !doc_ack_o) checkOutput("timeout_without_ack", 1, 0);
      end
      prev_glu_p    = glu_rd_i | glu_wr_i;
      prev_glu_wr   = glu_wr_i;
      prev_doc_p    = doc_rd_i;
      prev_glu_addr = glu_addr_i;
      prev_doc_addr = doc_addr_i;
      prev_glu_data = glu_data_i;
      prev_glu_be   = glu_be_i;
    end
  end

  task automatic glu_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [BE_W-1:0] be, input bit to);
    ack_exp_t e;
    bit       got = 0;
    e.to = to;
    if (to)      e.q = '0;
    else if (wr) e.q = glu_q_model;
    else         e.q = rd_value(a);
    glu_q_model = e.q;
    exp_glu.push_back(e);
    glu_wr_i   = wr;
    glu_rd_i   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    glu_addr_i = a;
    glu_data_i = d;
    glu_be_i   = be;
    for (int i = 0; i < TO + 100; i++) begin
      @(posedge clk_i); #1;
      if (glu_ack_o) begin got = 1; break; end
    end
    glu_rd_i = 1'b0;
    glu_wr_i = 1'b0;
    if (!got) begin
      checkOutput("glu_ack_wait", 0, 1);
      exp_glu.delete();
    end
  endtask

  task automatic doc_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] q, input bit to);
    ack_exp_t e;
    bit       got = 0;
    e.q  = q;
    e.to = to;
    exp_doc.push_back(e);
    doc_rd_i   = 1'b1;
    doc_addr_i = a;
    for (int i = 0; i < TO + 100; i++) begin
      @(posedge clk_i); #1;
      if (doc_ack_o) begin got = 1; break; end
    end
    doc_rd_i = 1'b0;
    if (!got) begin
      checkOutput("doc_ack_wait", 0, 1);
      exp_doc.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_q"}, {glu_q_o, doc_q_o}, '0);
    checkOutput({tag, "_ctrl"}, {glu_ack_o, doc_ack_o, mem_rd_o, mem_wr_o, timeout_o, busy_o, mem_addr_o}, '0);
    checkOutput({tag, "_wdata"}, {mem_data_o, mem_be_o}, '0);
  endtask

  task automatic check_grant_order(input string name, input int n, input logic [7:0] exp);
    logic [7:0] packed_log = '0;
    foreach (grant_log[i]) packed_log = {packed_log[6:0], grant_log[i]};
    checkOutput({name, "_count"}, grant_log.size(), n);
    checkOutput(name, packed_log, exp);
  endtask

  task automatic applyStimulus(input int scenario);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] hold;
    bit                got;
    case (scenario)
      0: begin
        rsp_delay = 3; rsp_ovr_en = 1'b1; rsp_ovr = 32'hDEADBEEF;
        doc_txn(24'h001234, 32'hDEADBEEF, 1'b0);
        rsp_ovr_en = 1'b0;
        checkOutput("lone_doc_q_hold", doc_q_o, 32'hDEADBEEF);
      end
      1: begin
        rsp_delay = -1;
        grant_log.delete();
        fork
          glu_txn(1'b0, 24'h000010, '0, '0, 1'b0);
          doc_txn(24'h000020, rd_value(24'h000020), 1'b0);
        join
        check_grant_order("simul_order", 2, 8'b10);
      end
      2: begin
        hold = glu_q_model;
        glu_txn(1'b1, 24'h00ABCD, 32'h11223344, 4'h3, 1'b0);
        checkOutput("write_q_hold", glu_q_o, hold);
      end
      3: begin
        grant_log.delete();
        fork
          glu_txn(1'b0, 24'h000F00, '0, '0, 1'b0);
          for (int i = 0; i < 5; i++) begin
            a = ADDR_W'($urandom);
            doc_txn(a, rd_value(a), 1'b0);
          end
        join
        check_grant_order("starve_order", 6, 8'b111101);
      end
      4: begin
        rsp_delay = 0;
        doc_txn(24'h00C0DE, '0, 1'b1);
        checkOutput("timeout_doc_q", doc_q_o, 0);
        rsp_delay = 2;
        doc_txn(24'h000456, rd_value(24'h000456), 1'b0);
        glu_txn(1'b0, 24'h000789, '0, '0, 1'b0);
      end
      5: begin
        rsp_delay = 0;
        got = 0;
        doc_addr_i = 24'h0F0F0F;
        doc_rd_i   = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(posedge clk_i); #1;
          if (mem_rd_o) begin got = 1; break; end
        end
        checkOutput("rst_strobe_seen", got, 1);
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        doc_rd_i = 1'b0;
        glu_q_model = '0;
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        late_req = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        checkOutput("late_ready_busy", busy_o, 0);
        checkOutput("late_ready_doc_q", doc_q_o, 0);
        rsp_delay = 1;
        glu_txn(1'b0, 24'h000777, '0, '0, 1'b0);
      end
      default: begin
        rsp_delay = -1;
        fork
          for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
            glu_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, BE_W'($urandom), 1'b0);
          end
          for (int i = 0; i < 20; i++) begin
            logic [ADDR_W-1:0] ra;
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            #1;
            ra = ADDR_W'($urandom);
            doc_txn(ra, rd_value(ra), 1'b0);
          end
        join
      end
    endcase
    @(posedge clk_i); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    for (int s = 0; s <= 6; s++) begin
      $display("[TB] scenario %0d", s);
      applyStimulus(s);
    end
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("queues_drained", exp_glu.size() + exp_doc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
